// File: rtl/antirrebote_botones_pkg.sv
// Shared definitions for the push-button debouncer.
// - Default timing constants (50 MHz system clock).
// - Per-channel FSM state encoding.
// - Counter width helper.
package antirrebote_botones_pkg;

  // 10 ms of stable level at 50 MHz.
  localparam int unsigned CICLOS_ESTABLE_DEF  = 500000;
  // 500 ms from the press pulse to the first auto-repeat pulse.
  localparam int unsigned RETARDO_REPETIR_DEF = 25000000;
  // 200 ms between subsequent auto-repeat pulses.
  localparam int unsigned PERIODO_REPETIR_DEF = 10000000;
  // Auto-repeat is off unless a build asks for it.
  localparam int unsigned REPETIR_EN_DEF      = 0;

  typedef enum logic [1:0] {
    Suelto        = 2'd0,
    ValidaPresion = 2'd1,
    Presionado    = 2'd2,
    ValidaSuelta  = 2'd3
  } estado_e;

  // Counter width: $clog2 of the largest timing constant, at least one bit.
  function automatic int unsigned ancho_contador(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/antirrebote_canal.sv
// One debounced push-button channel.
// Two-flop synchroniser, four-state validation FSM, stability counter and
// optional auto-repeat counter. The pulse request is combinational and is
// registered by the top level together with the arbitration.
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   boton_in raw asynchronous button level, 1 = pressed
//   pulso    one-cycle request: press accepted or auto-repeat due
module antirrebote_canal
  import antirrebote_botones_pkg::*;
#(
  parameter int unsigned CICLOS_ESTABLE  = CICLOS_ESTABLE_DEF,
  parameter int unsigned RETARDO_REPETIR = RETARDO_REPETIR_DEF,
  parameter int unsigned PERIODO_REPETIR = PERIODO_REPETIR_DEF,
  parameter int unsigned REPETIR_EN      = REPETIR_EN_DEF,
  parameter int unsigned ANCHO           =
    ancho_contador(CICLOS_ESTABLE, RETARDO_REPETIR, PERIODO_REPETIR)
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_in,
  output logic pulso
);

  localparam logic [ANCHO-1:0] FIN_ESTABLE = ANCHO'(CICLOS_ESTABLE - 1);
  localparam logic [ANCHO-1:0] FIN_RETARDO = ANCHO'(RETARDO_REPETIR - 1);
  localparam logic [ANCHO-1:0] FIN_PERIODO = ANCHO'(PERIODO_REPETIR - 1);
  localparam logic [ANCHO-1:0] CNT_MAX     = '1;
  localparam logic [ANCHO-1:0] UNO         = ANCHO'(1);

  logic             sinc1_q, sinc2_q;
  estado_e          estado_q, estado_d;
  logic [ANCHO-1:0] cnt_q, cnt_d;
  logic [ANCHO-1:0] rep_q, rep_d;
  // Set once the first auto-repeat has fired; selects delay vs. period.
  logic             repetido_q, repetido_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      sinc1_q    <= 1'b0;
      sinc2_q    <= 1'b0;
      estado_q   <= Suelto;
      cnt_q      <= '0;
      rep_q      <= '0;
      repetido_q <= 1'b0;
    end else begin
      sinc1_q    <= boton_in;
      sinc2_q    <= sinc1_q;
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      repetido_q <= repetido_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    repetido_d = repetido_q;
    pulso      = 1'b0;
    unique case (estado_q)
      Suelto: begin
        if (sinc2_q) begin
          estado_d = ValidaPresion;
          cnt_d    = '0;
        end
      end
      ValidaPresion: begin
        if (!sinc2_q) begin
          estado_d = Suelto;
          cnt_d    = '0;
        end else if (cnt_q >= FIN_ESTABLE) begin
          estado_d   = Presionado;
          cnt_d      = '0;
          rep_d      = '0;
          repetido_d = 1'b0;
          pulso      = 1'b1;
        end else begin
          cnt_d = cnt_q + UNO;
        end
      end
      Presionado: begin
        if (!sinc2_q) begin
          // Repeat counter is left untouched so it resumes after a bounce.
          estado_d = ValidaSuelta;
          cnt_d    = '0;
        end else if (REPETIR_EN != 0) begin
          if ((!repetido_q && rep_q >= FIN_RETARDO) ||
              (repetido_q && rep_q >= FIN_PERIODO)) begin
            pulso      = 1'b1;
            rep_d      = '0;
            repetido_d = 1'b1;
          end else if (rep_q != CNT_MAX) begin
            rep_d = rep_q + UNO;
          end
        end
      end
      ValidaSuelta: begin
        if (sinc2_q) begin
          estado_d = Presionado;
          cnt_d    = '0;
        end else if (cnt_q >= FIN_ESTABLE) begin
          estado_d = Suelto;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + UNO;
        end
      end
      default: begin
        estado_d = Suelto;
        cnt_d    = '0;
      end
    endcase
  end

endmodule

// File: rtl/antirrebote_botones.sv
// Debouncer for the left/right page buttons.
// Two identical channels; this level only arbitrates simultaneous requests
// and registers the outputs.
//   clk                 system clock, rising edge
//   reset               synchronous, active-high
//   boton_izquierda_in  raw left button level, 1 = pressed
//   boton_derecha_in    raw right button level, 1 = pressed
//   boton_izquierda     one-cycle pulse per accepted left press/repeat
//   boton_derecha       one-cycle pulse per accepted right press/repeat
module antirrebote_botones
  import antirrebote_botones_pkg::*;
#(
  parameter int unsigned CICLOS_ESTABLE  = CICLOS_ESTABLE_DEF,
  parameter int unsigned RETARDO_REPETIR = RETARDO_REPETIR_DEF,
  parameter int unsigned PERIODO_REPETIR = PERIODO_REPETIR_DEF,
  parameter int unsigned REPETIR_EN      = REPETIR_EN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_izquierda_in,
  input  logic boton_derecha_in,
  output logic boton_izquierda,
  output logic boton_derecha
);

  logic pulso_izq, pulso_der;

  antirrebote_canal #(
    .CICLOS_ESTABLE (CICLOS_ESTABLE),
    .RETARDO_REPETIR(RETARDO_REPETIR),
    .PERIODO_REPETIR(PERIODO_REPETIR),
    .REPETIR_EN     (REPETIR_EN)
  ) u_canal_izq (
    .clk     (clk),
    .reset   (reset),
    .boton_in(boton_izquierda_in),
    .pulso   (pulso_izq)
  );

  antirrebote_canal #(
    .CICLOS_ESTABLE (CICLOS_ESTABLE),
    .RETARDO_REPETIR(RETARDO_REPETIR),
    .PERIODO_REPETIR(PERIODO_REPETIR),
    .REPETIR_EN     (REPETIR_EN)
  ) u_canal_der (
    .clk     (clk),
    .reset   (reset),
    .boton_in(boton_derecha_in),
    .pulso   (pulso_der)
  );

  // Simultaneous requests are ambiguous and dropped, not deferred. The
  // self-mask keeps an output from ever being high two cycles in a row.
  always_ff @(posedge clk) begin
    if (reset) begin
      boton_izquierda <= 1'b0;
      boton_derecha   <= 1'b0;
    end else begin
      boton_izquierda <= pulso_izq & ~pulso_der & ~boton_izquierda;
      boton_derecha   <= pulso_der & ~pulso_izq & ~boton_derecha;
    end
  end

endmodule

// File: tb/tb_antirrebote_botones.sv
module tb_antirrebote_botones;

  logic clk = 1'b0;
  logic reset;
  logic izq0, der0, izq1, der1;
  logic out_izq0, out_der0, out_izq1, out_der1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // No auto-repeat.
  antirrebote_botones #(
    .CICLOS_ESTABLE (4),
    .RETARDO_REPETIR(10),
    .PERIODO_REPETIR(3),
    .REPETIR_EN     (0)
  ) dut0 (
    .clk               (clk),
    .reset             (reset),
    .boton_izquierda_in(izq0),
    .boton_derecha_in  (der0),
    .boton_izquierda   (out_izq0),
    .boton_derecha     (out_der0)
  );

  // Auto-repeat enabled.
  antirrebote_botones #(
    .CICLOS_ESTABLE (4),
    .RETARDO_REPETIR(10),
    .PERIODO_REPETIR(3),
    .REPETIR_EN     (1)
  ) dut1 (
    .clk               (clk),
    .reset             (reset),
    .boton_izquierda_in(izq1),
    .boton_derecha_in  (der1),
    .boton_izquierda   (out_izq1),
    .boton_derecha     (out_der1)
  );

  // Inputs change at the falling edge; edge e is the e-th rising edge after
  // the call, and outputs are sampled at the falling edge that follows it.
  task automatic do_reset();
    reset = 1'b1;
    izq0 = 1'b0; der0 = 1'b0; izq1 = 1'b0; der1 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    izq0 = 1'b1; der0 = 1'b1; izq1 = 1'b1; der1 = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      tests++;
      if ({out_izq0, out_der0, out_izq1, out_der1} !== 4'b0000) begin
        fails++;
        $display("FAIL reset edge %0d: outputs=%b expected 0000", e,
                 {out_izq0, out_der0, out_izq1, out_der1});
      end
    end
    izq0 = 1'b0; der0 = 1'b0; izq1 = 1'b0; der1 = 1'b0;
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(negedge clk);
      tests++;
      if ({out_izq0, out_der0, out_izq1, out_der1} !== 4'b0000) begin
        fails++;
        $display("FAIL reset_idle edge %0d: outputs=%b expected 0000", e,
                 {out_izq0, out_der0, out_izq1, out_der1});
      end
    end
  endtask

  // Right held from edge 10: single pulse at edge 16, none on release.
  task automatic test_single_press();
    logic exp;
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      der0 = (e >= 10 && e <= 20);
      @(negedge clk);
      exp = (e == 16);
      tests++;
      if (out_der0 !== exp || out_izq0 !== 1'b0) begin
        fails++;
        $display("FAIL single_press edge %0d: der=%b izq=%b expected der=%b izq=0",
                 e, out_der0, out_izq0, exp);
      end
    end
  endtask

  // Left 1,0,1,1,0 from edge 10, then held from 15: one pulse at edge 21.
  task automatic test_bounce_press();
    logic [4:0] pat;
    logic exp;
    pat = 5'b01101;
    do_reset();
    for (int e = 1; e <= 46; e++) begin
      if (e >= 10 && e <= 14) izq0 = pat[e-10];
      else                    izq0 = (e >= 15 && e <= 35);
      @(negedge clk);
      exp = (e == 21);
      tests++;
      if (out_izq0 !== exp || out_der0 !== 1'b0) begin
        fails++;
        $display("FAIL bounce_press edge %0d: izq=%b der=%b expected izq=%b der=0",
                 e, out_izq0, out_der0, exp);
      end
    end
  endtask

  // Right held edges 10..49 with repeat: pulses 16, 26, 29, ..., 50.
  task automatic test_repeat();
    logic exp;
    do_reset();
    for (int e = 1; e <= 70; e++) begin
      der1 = (e >= 10 && e <= 49);
      @(negedge clk);
      exp = (e == 16) || (e >= 26 && e <= 50 && ((e - 26) % 3) == 0);
      tests++;
      if (out_der1 !== exp || out_izq1 !== 1'b0) begin
        fails++;
        $display("FAIL repeat edge %0d: der=%b izq=%b expected der=%b izq=0",
                 e, out_der1, out_izq1, exp);
      end
    end
  endtask

  // Both buttons pressed together: every coincident request is dropped.
  task automatic test_both();
    do_reset();
    for (int e = 1; e <= 42; e++) begin
      izq0 = (e >= 10 && e <= 30);
      der0 = izq0;
      izq1 = izq0;
      der1 = izq0;
      @(negedge clk);
      tests++;
      if ({out_izq0, out_der0, out_izq1, out_der1} !== 4'b0000) begin
        fails++;
        $display("FAIL both edge %0d: outputs=%b expected 0000", e,
                 {out_izq0, out_der0, out_izq1, out_der1});
      end
    end
  endtask

  // Reset on edges 14..16 while left is being validated; revalidation from
  // edge 17 gives a single pulse at edge 23.
  task automatic test_reset_mid_press();
    logic exp;
    do_reset();
    for (int e = 1; e <= 46; e++) begin
      izq0  = (e >= 10 && e <= 35);
      reset = (e >= 14 && e <= 16);
      @(negedge clk);
      exp = (e == 23);
      tests++;
      if (out_izq0 !== exp || out_der0 !== 1'b0) begin
        fails++;
        $display("FAIL reset_mid_press edge %0d: izq=%b der=%b expected izq=%b der=0",
                 e, out_izq0, out_der0, exp);
      end
    end
    reset = 1'b0;
  endtask

  // Release glitch at edge 30 while pressed. Without repeat: no extra pulse.
  // With repeat: counter freezes across the glitch and resumes (34, 37, ...).
  task automatic test_release_bounce();
    logic exp0, exp1;
    do_reset();
    for (int e = 1; e <= 62; e++) begin
      der0 = (e >= 10 && e <= 45 && e != 30);
      der1 = der0;
      @(negedge clk);
      exp0 = (e == 16);
      exp1 = (e == 16) || (e == 26) || (e == 29) ||
             (e >= 34 && e <= 46 && ((e - 34) % 3) == 0);
      tests++;
      if (out_der0 !== exp0 || out_izq0 !== 1'b0) begin
        fails++;
        $display("FAIL release_bounce edge %0d: der=%b izq=%b expected der=%b izq=0",
                 e, out_der0, out_izq0, exp0);
      end
      tests++;
      if (out_der1 !== exp1 || out_izq1 !== 1'b0) begin
        fails++;
        $display("FAIL release_bounce_rep edge %0d: der=%b izq=%b expected der=%b izq=0",
                 e, out_der1, out_izq1, exp1);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    izq0 = 1'b0; der0 = 1'b0; izq1 = 1'b0; der1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_bounce_press();
    test_repeat();
    test_both();
    test_reset_mid_press();
    test_release_bounce();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/antirrebote_botones.md
ANTIRREBOTE_BOTONES -- requirements
Module: antirrebote_botones

Interface
REQ-001 SHALL have parameter CICLOS_ESTABLE, default 500000, consecutive stable synchronised samples needed to accept a level change (10 ms at 50 MHz).
REQ-002 SHALL have parameter RETARDO_REPETIR, default 25000000, cycles from first press pulse to first auto-repeat pulse.
REQ-003 SHALL have parameter PERIODO_REPETIR, default 10000000, cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have parameter REPETIR_EN, default 0; 0 disables auto-repeat, 1 enables it.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 boton_izquierda_in  input  1  raw asynchronous left push-button level, 1 = pressed.
REQ-008 boton_derecha_in  input  1  raw asynchronous right push-button level, 1 = pressed.
REQ-009 boton_izquierda  output  1  registered one-cycle pulse per accepted left press/repeat; feeds the page counter.
REQ-010 boton_derecha  output  1  registered one-cycle pulse per accepted right press/repeat; feeds the page counter.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchroniser; only the second flop's output is used downstream.
REQ-012 Each channel SHALL run an FSM: SUELTO, VALIDA_PRESION, PRESIONADO, VALIDA_SUELTA.
REQ-013 SUELTO: on synchronised 1, go to VALIDA_PRESION with stability counter cleared; otherwise stay.
REQ-014 VALIDA_PRESION: counter increments each cycle input stays 1; any 0 sample returns to SUELTO and clears counter (bounce rejected).
REQ-015 When counter reaches CICLOS_ESTABLE-1 with input still 1, channel SHALL enter PRESIONADO and assert its pulse for exactly the next cycle.
REQ-016 Latency: button held steadily from edge k SHALL produce the pulse at edge k+2+CICLOS_ESTABLE (±0), checked at sim parameters.
REQ-017 PRESIONADO: a 0 sample SHALL move to VALIDA_SUELTA; release validation mirrors REQ-014/015 with roles inverted, ending in SUELTO with no pulse.
REQ-018 Bounce during VALIDA_SUELTA SHALL return to PRESIONADO without emitting a pulse.
REQ-019 With REPETIR_EN=1, in PRESIONADO a repeat counter SHALL emit a pulse RETARDO_REPETIR cycles after the press pulse, then every PERIODO_REPETIR cycles while held.
REQ-020 Repeat counter SHALL clear on entering PRESIONADO and freeze in VALIDA_SUELTA; resume in PRESIONADO without clearing.
REQ-021 Counters SHALL be sized $clog2 of largest parameter, never wrap, and saturate at terminal count.
REQ-022 If both channels would pulse in the same cycle, both outputs SHALL be 0 that cycle (ambiguous input suppressed); no pulse is deferred.
REQ-023 Outputs SHALL never be high two consecutive cycles.

Reset
REQ-024 reset=1 SHALL force both FSMs to SUELTO, all counters and synchroniser flops to 0, both outputs to 0 on the next edge.
REQ-025 Reset asserted mid-press SHALL discard progress; a button still held after reset deasserts SHALL be revalidated and produce one pulse per REQ-016.
REQ-026 Reset SHALL take priority over all other inputs.

Structure
REQ-027 Default timing constants and FSM state encodings SHALL live in the shared project package/header, not local literals.
REQ-028 One sub-module, antirrebote_canal (synchroniser, FSM, counters, pulse for one button), SHALL be instantiated twice; top holds only REQ-022 arbitration and output registers.

Verification (CICLOS_ESTABLE=4, RETARDO_REPETIR=10, PERIODO_REPETIR=3)
REQ-029 Right held from edge 10, REPETIR_EN=0 -> boton_derecha high only at edge 16; no further pulse while held or on release.
REQ-030 Left toggled 1,0,1,1,0 then held -> no pulse until 4 stable synced samples after last 0; exactly one pulse.
REQ-031 REPETIR_EN=1, right held 40 cycles -> pulses at t0, t0+10, t0+13, t0+16, ...; none after validated release.
REQ-032 Both buttons rising same edge, held -> both outputs 0 at validation edge; no later pulses.
REQ-033 reset asserted 2 cycles into VALIDA_PRESION, button held -> no pulse during reset; one pulse 2+4 edges after reset deasserts.
REQ-034 Release bounce 1,0,1 within PRESIONADO -> no extra pulse; channel remains PRESIONADO.
